// File: rtl/irq_ctrl.sv
// Priority interrupt controller: MASK/PEND/EDGE registers feeding a REQ/SERVICE handshake with the PC.
// irq is raised one cycle after a qualifying cycle; the request holds through stall and is never preempted.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_src,
  input  logic [31:0] ia,
  input  logic        stall,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic [2:0]  irq_id,
  output logic        in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] VECTOR = 32'h8000_0008;

  state_t     state, state_nxt;
  logic [2:0] id_nxt;
  logic [2:0] win;
  logic [7:0] mask_r, edge_r, pend_edge, src_q;
  logic [7:0] src_rise, pend_clr, pend, active;
  logic       unused_bits;

  assign unused_bits = ^wr_data[31:8];

  assign src_rise = irq_src & ~src_q;
  assign pend_clr = (wr_en && wr_addr == 2'd1) ? wr_data[7:0] : 8'h00;
  // Level-mode bits mirror the sampled source; only edge-mode bits hold sticky state.
  assign pend     = (edge_r & pend_edge) | (~edge_r & src_q);
  assign active   = pend & mask_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= 8'h00;
      mask_r    <= 8'h00;
      edge_r    <= 8'h00;
      pend_edge <= 8'h00;
      state     <= IDLE;
      irq_id    <= 3'd0;
    end else begin
      src_q <= irq_src;
      if (wr_en && wr_addr == 2'd0) mask_r <= wr_data[7:0];
      if (wr_en && wr_addr == 2'd2) edge_r <= wr_data[7:0];
      // A rising edge beats a same-cycle software clear.
      pend_edge <= edge_r & (src_rise | (pend_edge & ~pend_clr));
      state     <= state_nxt;
      irq_id    <= id_nxt;
    end
  end

  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    case (state)
      IDLE: begin
        if (active != 8'h00 && !ia[31]) begin
          state_nxt = REQ;
          id_nxt    = win;
        end
      end
      REQ: begin
        if (ia == VECTOR)          state_nxt = SERVICE;
        else if (stall)            state_nxt = REQ;
        else if (!active[irq_id])  state_nxt = IDLE;
        else if (ia[31])           state_nxt = IDLE;
      end
      SERVICE: begin
        if (!ia[31]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign irq        = (state == REQ);
  assign in_service = (state == SERVICE);

  always_comb begin
    rd_data = 32'h0;
    case (rd_addr)
      2'd0: rd_data = {24'h0, mask_r};
      2'd1: rd_data = {24'h0, pend};
      2'd2: rd_data = {24'h0, edge_r};
      2'd3: rd_data = {26'h0, state, in_service, irq_id};
      default: rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus pushes expected snapshots, a negedge monitor pops and compares.
// Latency: each snapshot is compared at the negedge following its enqueue.
// Backpressure: none; the stimulus drives the DUT directly and the monitor never stalls it.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic [31:0] ia;
    logic        stall;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        irq;
    logic [2:0]  irq_id;
    logic        in_service;

    localparam logic [1:0] A_MASK = 2'd0, A_PEND = 2'd1, A_EDGE = 2'd2, A_STAT = 2'd3;
    localparam logic [31:0] VEC = 32'h8000_0008;

    typedef struct {
        string       name;
        logic        irq;
        logic [2:0]  id;
        logic        ins;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    irq_ctrl dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .ia(ia), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .irq(irq), .irq_id(irq_id), .in_service(in_service)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({irq, irq_id, in_service, rd_data} !== {e.irq, e.id, e.ins, e.rd}) begin
                n_errors++;
                $display("FAIL %s: got irq=%b id=%0d insvc=%b rd=%h, expected irq=%b id=%0d insvc=%b rd=%h",
                         e.name, irq, irq_id, in_service, rd_data, e.irq, e.id, e.ins, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0; wr_data = 32'h0;
    endtask

    task automatic chk(input string nm, input logic ei, input logic [2:0] eid,
                       input logic eins, input logic [1:0] ra, input logic [31:0] erd);
        rd_addr = ra;
        exp_q.push_back('{nm, ei, eid, eins, erd});
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; irq_src = 8'h00; ia = 32'h0000_0100; stall = 1'b0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 32'h0; rd_addr = 2'd0;
        tick(); tick();
        chk("reset_state", 0, 0, 0, A_STAT, 32'h0);
        reset = 1'b0;
        tick();

        wr(A_MASK, 32'hFF);
        irq_src = 8'h20;
        tick();
        chk("pend_level", 0, 0, 0, A_PEND, 32'h20);
        tick();
        chk("req_id5", 1, 5, 0, A_STAT, 32'h15);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 1, 5, 0, A_STAT, 32'h15);
        end
        stall = 1'b0; ia = VEC;
        tick();
        chk("service5", 0, 5, 1, A_STAT, 32'h2D);

        ia = 32'h8000_0010; irq_src = 8'h22;
        tick();
        chk("no_preempt", 0, 5, 1, A_STAT, 32'h2D);
        tick();
        ia = 32'h0000_0104;
        tick();
        chk("svc_exit", 0, 5, 0, A_STAT, 32'h05);
        tick();
        chk("req_id1", 1, 1, 0, A_STAT, 32'h11);

        irq_src = 8'h00;
        tick(); tick();
        chk("withdraw_src", 0, 1, 0, A_STAT, 32'h01);

        ia = 32'h8000_0100;
        wr(A_EDGE, 32'h01);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        chk("edge_set", 0, 1, 0, A_PEND, 32'h01);
        tick();
        chk("edge_sticky", 0, 1, 0, A_PEND, 32'h01);
        irq_src = 8'h01;
        wr(A_PEND, 32'h01);
        chk("edge_set_wins", 0, 1, 0, A_PEND, 32'h01);
        wr(A_PEND, 32'h01);
        chk("edge_w1c", 0, 1, 0, A_PEND, 32'h00);

        wr(A_EDGE, 32'h00);
        wr(A_MASK, 32'h00);
        ia = 32'h0000_0100; irq_src = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("masked", 0, 1, 0, A_PEND, 32'hFF);
        end
        wr(A_MASK, 32'h80);
        tick();
        chk("req_id7", 1, 7, 0, A_STAT, 32'h17);
        wr(A_PEND, 32'hFF);
        chk("level_w1c_ignored", 1, 7, 0, A_PEND, 32'hFF);
        ia = VEC;
        tick();
        chk("service7", 0, 7, 1, A_STAT, 32'h2F);
        ia = 32'h8000_0100;
        tick();

        reset = 1'b1;
        chk("reset_in_service", 0, 0, 0, A_STAT, 32'h0);
        tick();
        chk("reset_mask", 0, 0, 0, A_MASK, 32'h0);
        reset = 1'b0; ia = 32'h0000_0100;
        wr(A_MASK, 32'hFFFF_FF04);
        tick();
        chk("post_reset_req", 1, 2, 0, A_STAT, 32'h12);

        ia = 32'h8000_0000;
        tick();
        chk("withdraw_kernel", 0, 2, 0, A_STAT, 32'h02);
        wr(2'd3, 32'hFF);
        chk("addr3_ignored", 0, 2, 0, A_MASK, 32'h04);

        tick();
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected snapshots never compared", exp_q.size());
        end
        if (n_checks < 12) begin
            n_errors++;
            $display("FAIL coverage: only %0d checks ran", n_checks);
        end
        if (n_errors == 0)
            $display("PASS: %0d checks, 0 errors", n_checks);
        else
            $display("FAIL: %0d checks, %0d errors", n_checks, n_errors);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
